// File: rtl/sprite_fifo.sv
// sprite_fifo: show-ahead circular FIFO that carries sprite descriptors from
// the processor to the graphics pipeline in the clk_pixel domain.
// Optional build macro SPRITE_FIFO_CLIP_EN discards pushes whose coordinates
// or frame index lie outside the canvas and counts them as drops.
module sprite_fifo #(
  parameter int CANVAS_WIDTH  = 360,
  parameter int CANVAS_HEIGHT = 720,
  parameter int NUM_FRAMES    = 18,
  parameter int DEPTH         = 64
) (
  input  logic                          clk_pixel,
  input  logic                          sys_rst,
  input  logic                          new_frame,
  input  logic                          sprite_valid_in,
  input  logic [$clog2(CANVAS_WIDTH)-1:0]  sprite_x_in,
  input  logic [$clog2(CANVAS_HEIGHT)-1:0] sprite_y_in,
  input  logic [$clog2(NUM_FRAMES)-1:0]    sprite_frame_in,
  output logic                          sprite_valid_out,
  output logic [$clog2(CANVAS_WIDTH)-1:0]  sprite_x_out,
  output logic [$clog2(CANVAS_HEIGHT)-1:0] sprite_y_out,
  output logic [$clog2(NUM_FRAMES)-1:0]    sprite_frame_out,
  input  logic                          sprite_ready_in,
  output logic [$clog2(DEPTH):0]        count_out,
  output logic                          full_out,
  output logic                          empty_out,
  output logic [15:0]                   drop_count_out
);

  localparam int XW = $clog2(CANVAS_WIDTH);
  localparam int YW = $clog2(CANVAS_HEIGHT);
  localparam int FW = $clog2(NUM_FRAMES);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = XW + YW + FW;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_addr;
  logic [EW-1:0] head;
  logic          in_range;
  logic          full;
  logic          drop;
  logic          push;
  logic          pop;

`ifdef SPRITE_FIFO_CLIP_EN
  // Reject descriptors that would land outside the canvas or animation table
  always_comb begin
    in_range = (32'(sprite_x_in) < CANVAS_WIDTH) &&
               (32'(sprite_y_in) < CANVAS_HEIGHT) &&
               (32'(sprite_frame_in) < NUM_FRAMES);
  end
`else
  // Every descriptor is accepted as-is when clipping is not built in
  always_comb begin
    in_range = 1'b1;
  end
`endif

  // Push/pop/drop decisions; a flush frees the whole buffer, so a push that
  // coincides with new_frame is always kept even if the FIFO was full
  always_comb begin
    full    = (count == CW'(DEPTH));
    pop     = sprite_valid_out && sprite_ready_in;
    drop    = sprite_valid_in && (!in_range || (full && !pop && !new_frame));
    push    = sprite_valid_in && !drop;
    wr_addr = new_frame ? '0 : wr_ptr;
  end

  // Storage array has no reset; stale contents are masked by the count
  always_ff @(posedge clk_pixel) begin
    if (push && !sys_rst) begin
      mem[wr_addr] <= {sprite_x_in, sprite_y_in, sprite_frame_in};
    end
  end

  // Pointer and occupancy bookkeeping, with flush on new_frame
  always_ff @(posedge clk_pixel) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (new_frame) begin
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : '0;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Saturating drop counter; survives frame flushes, cleared only by reset
  always_ff @(posedge clk_pixel) begin
    if (sys_rst) begin
      drop_count_out <= '0;
    end else if (drop && (drop_count_out != 16'hFFFF)) begin
      drop_count_out <= drop_count_out + 16'd1;
    end
  end

  // Show-ahead head presentation; fields read zero whenever nothing is held
  always_comb begin
    sprite_valid_out = (count != '0);
    head             = sprite_valid_out ? mem[rd_ptr] : '0;
    sprite_x_out     = head[EW-1 -: XW];
    sprite_y_out     = head[FW +: YW];
    sprite_frame_out = head[FW-1:0];
    count_out        = count;
    full_out         = full;
    empty_out        = (count == '0);
  end

endmodule

// File: tb/tb_sprite_fifo.sv
// tb_sprite_fifo: directed self-checking bench for sprite_fifo using
// hand-computed expected values. Honours SPRITE_FIFO_CLIP_EN if defined.
module tb_sprite_fifo;

  localparam int XW = $clog2(360);
  localparam int YW = $clog2(720);
  localparam int FW = $clog2(18);
  localparam int CW = $clog2(64) + 1;

  logic          clk_pixel = 1'b0;
  logic          sys_rst;
  logic          new_frame;
  logic          sprite_valid_in;
  logic [XW-1:0] sprite_x_in;
  logic [YW-1:0] sprite_y_in;
  logic [FW-1:0] sprite_frame_in;
  logic          sprite_valid_out;
  logic [XW-1:0] sprite_x_out;
  logic [YW-1:0] sprite_y_out;
  logic [FW-1:0] sprite_frame_out;
  logic          sprite_ready_in;
  logic [CW-1:0] count_out;
  logic          full_out;
  logic          empty_out;
  logic [15:0]   drop_count_out;

  int total = 0;
  int bad   = 0;

  sprite_fifo #(
    .CANVAS_WIDTH (360),
    .CANVAS_HEIGHT(720),
    .NUM_FRAMES   (18),
    .DEPTH        (64)
  ) dut (
    .clk_pixel       (clk_pixel),
    .sys_rst         (sys_rst),
    .new_frame       (new_frame),
    .sprite_valid_in (sprite_valid_in),
    .sprite_x_in     (sprite_x_in),
    .sprite_y_in     (sprite_y_in),
    .sprite_frame_in (sprite_frame_in),
    .sprite_valid_out(sprite_valid_out),
    .sprite_x_out    (sprite_x_out),
    .sprite_y_out    (sprite_y_out),
    .sprite_frame_out(sprite_frame_out),
    .sprite_ready_in (sprite_ready_in),
    .count_out       (count_out),
    .full_out        (full_out),
    .empty_out       (empty_out),
    .drop_count_out  (drop_count_out)
  );

  // 10 ns pixel clock
  always #5 clk_pixel = ~clk_pixel;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, advance past the edge, then drop the strobes
  task automatic applyStimulus(input logic v, input int x, input int y,
                               input int f, input logic rdy, input logic nf);
    sprite_valid_in = v;
    sprite_x_in     = XW'(x);
    sprite_y_in     = YW'(y);
    sprite_frame_in = FW'(f);
    sprite_ready_in = rdy;
    new_frame       = nf;
    @(posedge clk_pixel);
    #1;
    sprite_valid_in = 1'b0;
    new_frame       = 1'b0;
  endtask

  // Guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sys_rst         = 1'b1;
    new_frame       = 1'b0;
    sprite_valid_in = 1'b0;
    sprite_x_in     = '0;
    sprite_y_in     = '0;
    sprite_frame_in = '0;
    sprite_ready_in = 1'b0;
    repeat (2) @(posedge clk_pixel);
    #1;

    // Reset state
    checkOutput("rst_valid", 32'(sprite_valid_out), 0);
    checkOutput("rst_x", 32'(sprite_x_out), 0);
    checkOutput("rst_y", 32'(sprite_y_out), 0);
    checkOutput("rst_frame", 32'(sprite_frame_out), 0);
    checkOutput("rst_count", 32'(count_out), 0);
    checkOutput("rst_empty", 32'(empty_out), 1);
    checkOutput("rst_full", 32'(full_out), 0);
    checkOutput("rst_drop", 32'(drop_count_out), 0);
    sys_rst = 1'b0;

    // Single push, show-ahead with one-cycle latency, then held stable
    applyStimulus(1'b1, 10, 20, 3, 1'b0, 1'b0);
    checkOutput("push1_valid", 32'(sprite_valid_out), 1);
    checkOutput("push1_x", 32'(sprite_x_out), 10);
    checkOutput("push1_y", 32'(sprite_y_out), 20);
    checkOutput("push1_frame", 32'(sprite_frame_out), 3);
    checkOutput("push1_count", 32'(count_out), 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
      checkOutput("hold_valid", 32'(sprite_valid_out), 1);
      checkOutput("hold_x", 32'(sprite_x_out), 10);
      checkOutput("hold_y", 32'(sprite_y_out), 20);
      checkOutput("hold_frame", 32'(sprite_frame_out), 3);
    end
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
    checkOutput("pop1_empty", 32'(empty_out), 1);
    checkOutput("pop1_valid", 32'(sprite_valid_out), 0);

    // Fill to 64, overflow push is dropped, then drain in order without gaps
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, i, i + 100, i % 18, 1'b0, 1'b0);
    end
    checkOutput("fill_full", 32'(full_out), 1);
    checkOutput("fill_count", 32'(count_out), 64);
    applyStimulus(1'b1, 99, 0, 0, 1'b0, 1'b0);
    checkOutput("ovf_drop", 32'(drop_count_out), 1);
    checkOutput("ovf_full", 32'(full_out), 1);
    checkOutput("ovf_count", 32'(count_out), 64);
    for (int i = 0; i < 64; i++) begin
      checkOutput("drain_valid", 32'(sprite_valid_out), 1);
      checkOutput("drain_x", 32'(sprite_x_out), 32'(i));
      checkOutput("drain_y", 32'(sprite_y_out), 32'(i + 100));
      checkOutput("drain_frame", 32'(sprite_frame_out), 32'(i % 18));
      applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
    end
    checkOutput("drain_empty", 32'(empty_out), 1);
    checkOutput("drain_count", 32'(count_out), 0);

    // Full with simultaneous push and pop: accepted, count stays at 64
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, i + 200, 5, 1, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 7, 5, 1, 1'b1, 1'b0);
    checkOutput("fullpp_count", 32'(count_out), 64);
    checkOutput("fullpp_drop", 32'(drop_count_out), 1);
    for (int i = 0; i < 64; i++) begin
      checkOutput("fullpp_x", 32'(sprite_x_out), (i < 63) ? 32'(201 + i) : 32'd7);
      applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
    end
    checkOutput("fullpp_empty", 32'(empty_out), 1);

    // Push and pop together while not full leaves the count unchanged
    applyStimulus(1'b1, 11, 1, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 12, 2, 2, 1'b1, 1'b0);
    checkOutput("pp_count", 32'(count_out), 1);
    checkOutput("pp_x", 32'(sprite_x_out), 12);

    // Five stored, flush with a coincident push keeps only that push
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 30 + i, 0, 0, 1'b0, 1'b0);
    end
    checkOutput("pre_flush_count", 32'(count_out), 5);
    applyStimulus(1'b1, 42, 6, 4, 1'b0, 1'b1);
    checkOutput("flush_count", 32'(count_out), 1);
    checkOutput("flush_x", 32'(sprite_x_out), 42);
    checkOutput("flush_frame", 32'(sprite_frame_out), 4);
    checkOutput("flush_drop", 32'(drop_count_out), 1);

    // Pop coinciding with a flush still ends empty
    applyStimulus(1'b1, 43, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b1);
    checkOutput("popflush_count", 32'(count_out), 0);
    checkOutput("popflush_valid", 32'(sprite_valid_out), 0);

    // Out-of-canvas x: discarded only when clipping is built in
    applyStimulus(1'b1, 360, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 359, 0, 0, 1'b0, 1'b0);
`ifdef SPRITE_FIFO_CLIP_EN
    checkOutput("clip_drop", 32'(drop_count_out), 2);
    checkOutput("clip_count", 32'(count_out), 1);
    checkOutput("clip_x", 32'(sprite_x_out), 359);
`else
    checkOutput("clip_drop", 32'(drop_count_out), 1);
    checkOutput("clip_count", 32'(count_out), 2);
    checkOutput("clip_x", 32'(sprite_x_out), 360);
`endif

    // Reset mid-drain clears everything on the next edge
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, i + 50, 0, 0, 1'b0, 1'b0);
    end
    checkOutput("pre_rst_count", 32'(count_out), 10);
    sys_rst = 1'b1;
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
    checkOutput("midrst_valid", 32'(sprite_valid_out), 0);
    checkOutput("midrst_count", 32'(count_out), 0);
    checkOutput("midrst_drop", 32'(drop_count_out), 0);
    checkOutput("midrst_empty", 32'(empty_out), 1);
    checkOutput("midrst_x", 32'(sprite_x_out), 0);
    sys_rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
